// File: rtl/data_sram_responder.sv
// Data-memory slave: byte-writable word RAM behind an sram-like request port,
// answering in request order after a fixed latency with bounded outstanding requests.
module data_sram_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2,
  parameter int DEPTH      = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [31:0]           mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  hs;
  logic [31:0]           rd_word;
  logic [CW-1:0]         count;
  logic [LATENCY-1:0]    pipe_v;
  logic [31:0]           pipe_w [LATENCY];
  logic                  unused_addr_bits;

  assign idx              = data_addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{data_addr[31:ADDR_WIDTH+2], data_addr[1:0]};

  // A retiring response frees its slot in the same cycle, so full does not stall then.
  assign data_addr_ok = data_req && ((count < CW'(DEPTH)) || data_data_ok);
  assign hs           = data_req && data_addr_ok;
  assign rd_word      = data_wr ? 32'h0 : mem[idx];

  // NOTE: the RAM array has no reset; clearing it would prevent block-RAM mapping
  // and contents are required to survive resetn anyway.
  always_ff @(posedge clk) begin
    if (hs && data_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_wen[i]) mem[idx][8*i +: 8] <= data_wdata[8*i +: 8];
      end
    end
  end

  // Last stage drives the outputs; words only move with a valid so data_rdata holds.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_w[i] <= 32'h0;
    end else begin
      pipe_v[0] <= hs;
      if (hs) pipe_w[0] <= rd_word;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        if (pipe_v[i-1]) pipe_w[i] <= pipe_w[i-1];
      end
    end
  end

  assign data_data_ok = pipe_v[LATENCY-1];
  assign data_rdata   = pipe_w[LATENCY-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      case ({hs, data_data_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: a DEPTH=2 and a DEPTH=1 instance share
// one stimulus bus; a reference byte-RAM model predicts every response word and cycle.
module tb_data_sram_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr, sel;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic        req0, req1, aok0, aok1, dok0, dok1, aok, dok;
  logic [31:0] rd0, rd1, rd;

  always #5 clk = ~clk;

  assign req0 = req & ~sel;
  assign req1 = req & sel;
  assign aok  = sel ? aok1 : aok0;
  assign dok  = sel ? dok1 : dok0;
  assign rd   = sel ? rd1  : rd0;

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(2)) dut (
    .clk(clk), .resetn(resetn), .data_req(req0), .data_wr(wr), .data_wen(wen),
    .data_addr(addr), .data_wdata(wdata), .data_addr_ok(aok0),
    .data_data_ok(dok0), .data_rdata(rd0)
  );

  data_sram_responder #(.ADDR_WIDTH(10), .LATENCY(2), .DEPTH(1)) dut_d1 (
    .clk(clk), .resetn(resetn), .data_req(req1), .data_wr(wr), .data_wen(wen),
    .data_addr(addr), .data_wdata(wdata), .data_addr_ok(aok1),
    .data_data_ok(dok1), .data_rdata(rd1)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic [31:0] word;
    int          due;
  } exp_t;

  op_t         ops[$];
  exp_t        sb[$];
  logic [31:0] model [2][1024];
  int          cyc = 0;
  int          total = 0;
  int          passed = 0;
  int          outst = 0;
  logic [31:0] last_rdata;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_op(input bit w, input logic [3:0] e, input logic [31:0] a,
                         input logic [31:0] d);
    op_t o;
    o.wr = w; o.wen = e; o.addr = a; o.wdata = d;
    ops.push_back(o);
  endtask

  // Issues queued ops with req held, predicts addr_ok, scores responses and accept spacing.
  task automatic run_ops(input int gap);
    int          i = 0;
    int          budget = 0;
    int          last_acc = -1;
    int          depth;
    int          k;
    bit          retire, exp_ok;
    op_t         o;
    exp_t        e;
    logic [31:0] wexp;
    depth = sel ? 1 : 2;
    while ((i < ops.size() || sb.size() > 0) && budget < 200) begin
      @(negedge clk);
      budget++;
      retire = dok;
      if (dok) begin
        total++;
        if (sb.size() == 0) begin
          $display("FAIL spurious_data_ok: got data_ok=1 at cycle %0d, required no pending response", cyc);
        end else begin
          e = sb.pop_front();
          last_rdata = rd;
          if (rd !== e.word || cyc != e.due)
            $display("FAIL response: got rdata=%h at cycle %0d, required %h at cycle %0d",
                     rd, cyc, e.word, e.due);
          else passed++;
        end
      end
      if (i < ops.size()) begin
        o = ops[i];
        req = 1'b1; wr = o.wr; wen = o.wen; addr = o.addr; wdata = o.wdata;
      end else begin
        req = 1'b0;
      end
      #1;
      if (req) begin
        exp_ok = (outst < depth) || retire;
        total++;
        if (aok !== exp_ok)
          $display("FAIL addr_ok: got %b at cycle %0d, required %b", aok, cyc, exp_ok);
        else passed++;
      end
      if (retire && outst > 0) outst--;
      if (req && aok) begin
        k = int'(o.addr[11:2]);
        if (o.wr) begin
          for (int b = 0; b < 4; b++)
            if (o.wen[b]) model[int'(sel)][k][8*b +: 8] = o.wdata[8*b +: 8];
          wexp = 32'h0;
        end else begin
          wexp = model[int'(sel)][k];
        end
        e.word = wexp; e.due = cyc + 2;
        sb.push_back(e);
        outst++;
        total++;
        if (outst > depth) $display("FAIL outstanding: got %0d, required <= %0d", outst, depth);
        else passed++;
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != gap)
            $display("FAIL accept_gap: got %0d cycles, required %0d", cyc - last_acc, gap);
          else passed++;
        end
        last_acc = cyc;
        i++;
      end
    end
    total++;
    if (i < ops.size() || sb.size() > 0)
      $display("FAIL timeout: got %0d ops issued and %0d responses pending, required all done",
               i, sb.size());
    else passed++;
    req = 1'b0;
    ops.delete();
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 1'b0; sel = 1'b0; wr = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
    repeat (2) @(negedge clk);
    total++;
    if (dok0 !== 1'b0 || rd0 !== 32'h0 || dok1 !== 1'b0 || rd1 !== 32'h0)
      $display("FAIL reset_outputs: got ok=%b/%b rdata=%h/%h, required 0/0 0/0", dok0, dok1, rd0, rd1);
    else passed++;
    total++;
    if (aok0 !== 1'b0) $display("FAIL reset_addr_ok: got %b, required 0", aok0);
    else passed++;
    resetn = 1'b1;
  endtask

  task automatic test_write_read();
    sel = 1'b0;
    push_op(1, 4'hF, 32'h10, 32'hDEADBEEF);
    push_op(0, 4'h0, 32'h10, 32'h0);
    run_ops(1);
    total++;
    if (last_rdata !== 32'hDEADBEEF) $display("FAIL read_back: got %h, required DEADBEEF", last_rdata);
    else passed++;
  endtask

  task automatic test_byte_write();
    sel = 1'b0;
    push_op(1, 4'b0100, 32'h12, 32'h00AA0000);
    push_op(1, 4'b0000, 32'h10, 32'hFFFFFFFF);
    push_op(0, 4'h0, 32'h10, 32'h0);
    run_ops(1);
    total++;
    if (last_rdata !== 32'hDEAABEEF) $display("FAIL byte_merge: got %h, required DEAABEEF", last_rdata);
    else passed++;
  endtask

  task automatic test_depth1();
    sel = 1'b1;
    push_op(1, 4'hF, 32'h0, 32'h11111111);
    push_op(1, 4'hF, 32'h4, 32'h22222222);
    push_op(1, 4'hF, 32'h8, 32'h33333333);
    push_op(0, 4'h0, 32'h0, 32'h0);
    push_op(0, 4'h0, 32'h4, 32'h0);
    push_op(0, 4'h0, 32'h8, 32'h0);
    run_ops(2);
    total++;
    if (last_rdata !== 32'h33333333) $display("FAIL depth1_last: got %h, required 33333333", last_rdata);
    else passed++;
    sel = 1'b0;
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    push_op(1, 4'hF, 32'h40, 32'hA0A0A0A0);
    push_op(1, 4'hF, 32'h44, 32'hB1B1B1B1);
    for (int n = 0; n < 6; n++) push_op(0, 4'h0, (n % 2 == 0) ? 32'h40 : 32'h44, 32'h0);
    run_ops(1);
  endtask

  task automatic test_reset_flush();
    int pulses = 0;
    sel = 1'b0;
    push_op(1, 4'hF, 32'h20, 32'hCAFEF00D);
    run_ops(1);
    @(negedge clk);
    req = 1'b1; wr = 1'b0; addr = 32'h20;
    #1;
    total++;
    if (aok !== 1'b1) $display("FAIL flush_accept1: got %b, required 1", aok); else passed++;
    @(negedge clk);
    addr = 32'h24;
    #1;
    total++;
    if (aok !== 1'b1) $display("FAIL flush_accept2: got %b, required 1", aok); else passed++;
    @(posedge clk);
    #1;
    req = 1'b0;
    total++;
    if (dok !== 1'b1 || rd !== 32'hCAFEF00D)
      $display("FAIL pre_reset_resp: got ok=%b rdata=%h, required 1 CAFEF00D", dok, rd);
    else passed++;
    resetn = 1'b0;
    #1;
    total++;
    if (dok !== 1'b0 || rd !== 32'h0)
      $display("FAIL async_reset: got ok=%b rdata=%h, required 0 00000000", dok, rd);
    else passed++;
    sb.delete();
    outst = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (dok) pulses++;
    end
    total++;
    if (pulses != 0) $display("FAIL late_pulse: got %0d data_ok pulses, required 0", pulses);
    else passed++;
    push_op(0, 4'h0, 32'h20, 32'h0);
    run_ops(1);
    total++;
    if (last_rdata !== 32'hCAFEF00D) $display("FAIL ram_kept: got %h, required CAFEF00D", last_rdata);
    else passed++;
  endtask

  task automatic test_alias();
    sel = 1'b0;
    push_op(1, 4'hF, 32'h1000, 32'h12345678);
    push_op(0, 4'h0, 32'h0000, 32'h0);
    run_ops(1);
    total++;
    if (last_rdata !== 32'h12345678) $display("FAIL alias: got %h, required 12345678", last_rdata);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_depth1();
    test_back_to_back();
    test_reset_flush();
    test_alias();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
